// File: rtl/serial_code_matcher.sv
// Serial bit-stream comparator for the code-entry path: checks X against Y over
// CODE_LEN qualified bits, then holds PASS or enforces a lockout after repeated failures.
module serial_code_matcher #(
    parameter int CODE_LEN    = 8,
    parameter int MAX_TRIES   = 3,
    parameter int HOLD_CYCLES = 100,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             START,
    input  logic                             BIT_VALID,
    input  logic                             X,
    input  logic                             Y,
    input  logic                             ABORT,
    output logic                             BUSY,
    output logic                             MATCH,
    output logic                             DONE,
    output logic                             PASS,
    output logic                             LOCKED,
    output logic [$clog2(MAX_TRIES+1)-1:0]   FAIL_CNT
);

    localparam int CW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LAST_BIT  = CW'(CODE_LEN - 1);
    localparam logic [FW-1:0] LAST_TRY  = FW'(MAX_TRIES - 1);
    localparam logic [FW-1:0] SAT_CNT   = FW'(MAX_TRIES);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_EVAL,
        S_HOLD,
        S_LOCKOUT
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [TW-1:0]   timer;

    // NOTE: every register here updates with <= so all reads in this block see
    // pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            timer    <= '0;
            BUSY     <= 1'b0;
            MATCH    <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            LOCKED   <= 1'b0;
            FAIL_CNT <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_COMPARE;
                        bit_cnt <= '0;
                        MATCH   <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    // Abort wins even against the final bit of the attempt.
                    if (ABORT) begin
                        state <= S_IDLE;
                        MATCH <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (BIT_VALID) begin
                        MATCH   <= MATCH & (X ~^ Y);
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_EVAL;
                            DONE  <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    BUSY  <= 1'b0;
                    timer <= '0;
                    if (MATCH) begin
                        FAIL_CNT <= '0;
                        PASS     <= 1'b1;
                        state    <= S_HOLD;
                    end else if (FAIL_CNT >= LAST_TRY) begin
                        FAIL_CNT <= SAT_CNT;
                        LOCKED   <= 1'b1;
                        state    <= S_LOCKOUT;
                    end else begin
                        FAIL_CNT <= FAIL_CNT + 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (timer == HOLD_LAST) begin
                        state <= S_IDLE;
                        PASS  <= 1'b0;
                        MATCH <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    // Lockout expiry also forgives the failure history.
                    if (timer == LOCK_LAST) begin
                        state    <= S_IDLE;
                        LOCKED   <= 1'b0;
                        FAIL_CNT <= '0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_matcher.sv
// Scoreboard bench for serial_code_matcher (8 bits, 3 tries, hold 4, lock 10):
// stimulus pushes expected outcomes, a monitor checks them whenever DONE pulses.
module tb_serial_code_matcher;

    localparam int CODE_LEN    = 8;
    localparam int MAX_TRIES   = 3;
    localparam int HOLD_CYCLES = 4;
    localparam int LOCK_CYCLES = 10;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       BIT_VALID = 1'b0;
    logic       X = 1'b0;
    logic       Y = 1'b0;
    logic       ABORT = 1'b0;
    logic       BUSY, MATCH, DONE, PASS, LOCKED;
    logic [1:0] FAIL_CNT;

    serial_code_matcher #(
        .CODE_LEN   (CODE_LEN),
        .MAX_TRIES  (MAX_TRIES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .BIT_VALID(BIT_VALID),
        .X        (X),
        .Y        (Y),
        .ABORT    (ABORT),
        .BUSY     (BUSY),
        .MATCH    (MATCH),
        .DONE     (DONE),
        .PASS     (PASS),
        .LOCKED   (LOCKED),
        .FAIL_CNT (FAIL_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         done_cyc;
        logic       pass;
        logic       locked;
        logic [1:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: DONE=1 at cycle %0d, expected no DONE", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("done_match", MATCH, e.pass);
                    check("done_busy", BUSY, 1);
                    @(negedge CLK);
                    check("outcome_pass", PASS, e.pass);
                    check("outcome_locked", LOCKED, e.locked);
                    check("outcome_fail_cnt", FAIL_CNT, e.fcnt);
                    check("done_one_cycle", DONE, 0);
                end
            end
        end
    end

    // Drives one attempt LSB first; returns at the negedge where DONE should show
    // (or right after the abort edge). gap_a/gap_b insert 2 stall cycles after that bit.
    task automatic run_attempt(input logic [7:0] xv, input logic [7:0] yv,
                               input int gap_a, input int gap_b, input int abort_at);
        int   ts;
        int   gaps;
        logic exp_m;
        exp_t e;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ts    = cyc;
        gaps  = 0;
        exp_m = 1'b1;
        check("start_match", MATCH, 1);
        check("start_busy", BUSY, 1);
        for (int i = 0; i < CODE_LEN; i++) begin
            BIT_VALID = 1'b1;
            X         = xv[i];
            Y         = yv[i];
            ABORT     = (i == abort_at);
            if (i == CODE_LEN - 1 && abort_at != i) begin
                e.done_cyc = ts + CODE_LEN + gaps;
                e.pass     = (xv == yv);
                if (xv == yv) begin
                    model_fails = 0;
                    e.locked    = 1'b0;
                    e.fcnt      = 2'd0;
                end else begin
                    model_fails++;
                    e.locked = (model_fails == MAX_TRIES);
                    e.fcnt   = 2'(model_fails);
                    if (model_fails == MAX_TRIES) model_fails = 0;
                end
                sb.push_back(e);
            end
            @(negedge CLK);
            BIT_VALID = 1'b0;
            if (ABORT) begin
                ABORT = 1'b0;
                check("abort_busy", BUSY, 0);
                check("abort_match", MATCH, 0);
                check("abort_fail_cnt", FAIL_CNT, model_fails);
                return;
            end
            exp_m = exp_m & (xv[i] == yv[i]);
            check($sformatf("bit%0d_match", i), MATCH, exp_m);
            if (i == gap_a || i == gap_b) begin
                repeat (2) @(negedge CLK);
                gaps += 2;
            end
        end
    endtask

    // Counts consecutive PASS-high cycles starting at the next negedge.
    task automatic count_pass(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (PASS === 1'b1) n++;
            else if (n > 0) break;
        end
        check({name, "_pass_len"}, n, HOLD_CYCLES);
        check({name, "_idle_busy"}, BUSY, 0);
        check({name, "_idle_match"}, MATCH, 0);
    endtask

    task automatic run_lockout(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            START = 1'b0;
            if (LOCKED === 1'b1) begin
                n++;
                check({name, "_lock_busy"}, BUSY, 0);
                if (n == 3 || n == 7) START = 1'b1;
            end else begin
                break;
            end
        end
        START = 1'b0;
        check({name, "_lock_len"}, n, LOCK_CYCLES);
        check({name, "_lock_exit_fail_cnt"}, FAIL_CNT, 0);
        check({name, "_lock_exit_busy"}, BUSY, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_match", MATCH, 0);
        check("rst_done", DONE, 0);
        check("rst_pass", PASS, 0);
        check("rst_locked", LOCKED, 0);
        check("rst_fail_cnt", FAIL_CNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Clean pass, then single fail at bit 3.
        run_attempt(8'hA5, 8'hA5, -1, -1, -1);
        count_pass("pass1");
        run_attempt(8'hA5, 8'hA5 ^ 8'h08, -1, -1, -1);
        @(negedge CLK);
        check("fail1_idle_busy", BUSY, 0);

        // Fail then pass with stalls after bits 2 and 6.
        run_attempt(8'h3C, 8'h3C, 2, 6, -1);
        count_pass("gap_pass");

        // Aborts keep the fail count.
        run_attempt(8'h5A, 8'h4A, -1, -1, -1);
        run_attempt(8'hA5, 8'hA5, -1, -1, 5);
        run_attempt(8'hA5, 8'hA5, -1, -1, 7);
        repeat (3) @(negedge CLK);
        check("after_abort_fail_cnt", FAIL_CNT, 1);
        run_attempt(8'hC3, 8'hC3, -1, -1, -1);
        count_pass("pass_after_fail");

        // Three failures in a row lock the block out.
        run_attempt(8'hA5, 8'hA5 ^ 8'h01, -1, -1, -1);
        run_attempt(8'hA5, 8'hA5 ^ 8'h80, -1, -1, -1);
        run_attempt(8'hA5, 8'h5A, -1, -1, -1);
        run_lockout("lock1");
        run_attempt(8'hA5, 8'hA5, -1, -1, -1);
        count_pass("pass_after_lock");

        // Asynchronous reset in the middle of HOLD.
        run_attempt(8'hFF, 8'hFF, -1, -1, -1);
        repeat (2) @(negedge CLK);
        check("mid_hold_pass", PASS, 1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_hold_pass", PASS, 0);
        check("rst_hold_match", MATCH, 0);
        check("rst_hold_fail_cnt", FAIL_CNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_fails = 0;

        // Asynchronous reset in the middle of LOCKOUT.
        run_attempt(8'h00, 8'h01, -1, -1, -1);
        run_attempt(8'h00, 8'h10, -1, -1, -1);
        run_attempt(8'h00, 8'hFF, -1, -1, -1);
        repeat (4) @(negedge CLK);
        check("mid_lock_locked", LOCKED, 1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_lock_locked", LOCKED, 0);
        check("rst_lock_fail_cnt", FAIL_CNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_fails = 0;

        // Normal operation after reset release.
        run_attempt(8'h96, 8'h96, -1, -1, -1);
        count_pass("pass_after_rst");

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_code_matcher.md
Name: serial_code_matcher

Overview:
Parametrised serial bit-sequence comparator. It compares an entered bit stream X against a reference stream Y, one bit per qualified cycle, over CODE_LEN bits. It reports pass or fail with a DONE pulse, and holds PASS for a programmable time instead of a simulation delay. Consecutive failures are counted, and the block locks out new attempts for a programmable period after MAX_TRIES failures. It sits between the input-capture logic and the unlock/indicator logic of the code-entry path.

Parameters:
CODE_LEN, 8, number of bits per comparison (>=1)
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1)
HOLD_CYCLES, 100, cycles PASS stays high after a successful match (>=1)
LOCK_CYCLES, 1000, cycles LOCKED stays high after lockout entry (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin an attempt; sampled only in IDLE
BIT_VALID  in  1  X/Y pair valid this cycle
X  in  1  entered bit
Y  in  1  reference bit
ABORT  in  1  cancel the attempt in progress
BUSY  out  1  attempt in progress (COMPARE or EVAL)
MATCH  out  1  running flag: all bits so far have X==Y
DONE  out  1  one-cycle pulse at the end of every completed attempt
PASS  out  1  high while holding after a successful match
LOCKED  out  1  high during lockout
FAIL_CNT  out  $clog2(MAX_TRIES+1)  current count of consecutive failures

Behaviour:
- Reset (RST_N=0, async):
  - state IDLE.
  - BUSY, MATCH, DONE, PASS, LOCKED = 0.
  - FAIL_CNT = 0; internal bit counter and hold/lock timer = 0.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- States: IDLE, COMPARE, EVAL, HOLD, LOCKOUT.
- IDLE:
  - START=1 at edge t -> COMPARE from t+1; bit_cnt=0, match_r=1.
  - MATCH shows 1 from t+1.
- COMPARE, on each edge with BIT_VALID=1:
  - match_r <= match_r & (X==Y); bit_cnt++.
  - BIT_VALID=0: stall, no state change.
  - Once match_r=0 it stays 0 for the rest of the attempt; MATCH falls the cycle after the first mismatching bit.
  - The edge that samples bit CODE_LEN-1 -> EVAL.
- ABORT in COMPARE:
  - -> IDLE next cycle; match_r cleared; no DONE; FAIL_CNT unchanged.
  - ABORT has priority over a simultaneous last bit.
  - ABORT is ignored in all other states.
- START outside IDLE is ignored.
- EVAL (exactly one cycle), DONE=1:
  - match_r=1: FAIL_CNT<=0, -> HOLD.
  - match_r=0 and FAIL_CNT+1 < MAX_TRIES: FAIL_CNT++, -> IDLE.
  - match_r=0 and FAIL_CNT+1 == MAX_TRIES: FAIL_CNT++ (saturates at MAX_TRIES), -> LOCKOUT.
- HOLD:
  - PASS=1 for exactly HOLD_CYCLES cycles, then -> IDLE.
  - MATCH stays 1 during HOLD and clears on the return to IDLE.
- LOCKOUT:
  - LOCKED=1 for exactly LOCK_CYCLES cycles; START ignored.
  - Exit -> IDLE with FAIL_CNT<=0.
- MATCH is 0 in IDLE and LOCKOUT.
- Latency: START edge t, back-to-back valid bits -> DONE at cycle t+CODE_LEN+1; PASS from t+CODE_LEN+2.
- Reset mid-attempt, HOLD or LOCKOUT: immediate return to reset values; the fail history is lost.
- Timer width is $clog2(max(HOLD_CYCLES,LOCK_CYCLES)+1); the counter must never wrap within a state.

Test Plan:
- Params 8/3/4/10. START, then 8 valid cycles with X=Y=8'hA5 -> MATCH=1 throughout, DONE pulse at cycle 9, PASS high for exactly 4 cycles, FAIL_CNT=0, IDLE after.
- Same, but X differs from Y at bit 3 -> MATCH falls the cycle after bit 3 and stays 0; DONE pulse, PASS=0, FAIL_CNT=1, IDLE the next cycle.
- Three failing attempts in a row -> third DONE followed by LOCKED high for 10 cycles; START pulses during lock are ignored; afterwards FAIL_CNT=0 and a passing attempt gives PASS.
- Fail, then pass -> FAIL_CNT 1 then 0. Passing attempt with BIT_VALID gaps (e.g. 2 idle cycles after bits 2 and 6) -> same result; DONE delayed by exactly 4 cycles.
- ABORT during bit 5 (including on the same cycle as bit 7 in a second run) -> IDLE, no DONE, FAIL_CNT unchanged, BUSY=0 next cycle.
- RST_N asserted mid-HOLD and mid-LOCKOUT -> PASS/LOCKED/FAIL_CNT go to 0 without waiting for a clock edge; normal operation after release.
